// File: rtl/centroid_update_unit.sv
// centroid_update_unit: walks the eight accumulator/count pairs after a
// classification pass and divides every coordinate sum by its point count
// with a serial restoring divider (one quotient bit per cycle). Each new
// centroid is written to centroid memory, then the accumulators are cleared.
//
// Optional feature macro: CENTROID_ROUND_NEAREST_EN
//   defined   -> quotient rounded half up (+1 when 2*rem >= count)
//   undefined -> quotient truncated (floor)
//   Either way the quotient then saturates to 13 bits (8191).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin an update pass (sampled only in IDLE)
//   rd_idx              centroid index driving the external accum/count mux
//   accum_in, cnt_in    accumulator (7 x 22 bit) and count of rd_idx
//   wr_en/wr_ready      centroid write handshake
//   wr_addr, wr_data    centroid address and new centroid (7 x 13 bit)
//   regs_clr_n          one-cycle active-low clear for the accumulator stage
//   busy, done          not-idle flag, end-of-pass pulse
//   empty_mask          centroids with zero count in the last pass
module centroid_update_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [2:0]   rd_idx,
    input  logic [153:0] accum_in,
    input  logic [9:0]   cnt_in,
    output logic         wr_en,
    input  logic         wr_ready,
    output logic [7:0]   wr_addr,
    output logic [90:0]  wr_data,
    output logic         regs_clr_n,
    output logic         busy,
    output logic         done,
    output logic [7:0]   empty_mask
);

    localparam int ACW = 22;
    localparam int OW  = 13;
    localparam int NW  = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIV, S_WRITE, S_CLEAR, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [153:0]  acc_q;
    logic [NW-1:0] cnt_q;
    logic [4:0]    step_q;
    logic [2:0]    k_q;
    logic [NW-1:0] rem_q;
    logic [20:0]   quo_q;
    logic [90:0]   res_q;
    logic [90:0]   wr_data_q;
    logic [2:0]    rd_idx_q;
    logic [7:0]    empty_q;

    logic [ACW-1:0] coord;
    logic           dbit;
    logic [NW:0]    rem_sh;
    logic           ge;
    logic [NW-1:0]  rem_n;
    logic [21:0]    quo_n;
    logic [22:0]    q_rnd;
    logic [OW-1:0]  q_sat;
    logic [90:0]    res_n;
    logic           last_step;
    logic           last_coord;
    logic           last_idx;

    assign last_step  = (step_q == 5'd21);
    assign last_coord = (k_q == 3'd6);
    assign last_idx   = (rd_idx_q == 3'd7);

    // One restoring step: shift in the next dividend bit (MSB first),
    // subtract the count when it fits. The remainder always stays below
    // the count, so 10 bits hold it between steps.
    always_comb begin
        coord  = acc_q[ACW*int'(k_q) +: ACW];
        dbit   = coord[5'd21 - step_q];
        rem_sh = {rem_q, dbit};
        ge     = (rem_sh >= {1'b0, cnt_q});
        rem_n  = ge ? 10'(rem_sh - {1'b0, cnt_q}) : rem_sh[NW-1:0];
        quo_n  = {quo_q, ge};
`ifdef CENTROID_ROUND_NEAREST_EN
        q_rnd  = {1'b0, quo_n}
               + {22'd0, ({rem_n, 1'b0} >= {1'b0, cnt_q})};
`else
        q_rnd  = {1'b0, quo_n};
`endif
        q_sat  = (q_rnd > 23'd8191) ? 13'h1FFF : q_rnd[OW-1:0];
        res_n  = res_q;
        res_n[OW*int'(k_q) +: OW] = q_sat;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (cnt_in == '0)
                    state_d = last_idx ? S_CLEAR : S_LOAD;
                else
                    state_d = S_DIV;
            end
            S_DIV:   if (last_step && last_coord) state_d = S_WRITE;
            S_WRITE: if (wr_ready) state_d = last_idx ? S_CLEAR : S_LOAD;
            S_CLEAR: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            step_q    <= '0;
            k_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_q     <= '0;
            wr_data_q <= '0;
            rd_idx_q  <= '0;
            empty_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rd_idx_q <= '0;
                        empty_q  <= '0;
                        k_q      <= '0;
                    end
                end
                S_LOAD: begin
                    acc_q  <= accum_in;
                    cnt_q  <= cnt_in;
                    k_q    <= '0;
                    step_q <= '0;
                    rem_q  <= '0;
                    quo_q  <= '0;
                    if (cnt_in == '0) begin
                        empty_q[rd_idx_q] <= 1'b1;
                        if (!last_idx) rd_idx_q <= rd_idx_q + 3'd1;
                    end
                end
                S_DIV: begin
                    if (last_step) begin
                        step_q <= '0;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        res_q  <= res_n;
                        if (last_coord) wr_data_q <= res_n;
                        else            k_q <= k_q + 3'd1;
                    end else begin
                        step_q <= step_q + 5'd1;
                        rem_q  <= rem_n;
                        quo_q  <= quo_n[20:0];
                    end
                end
                S_WRITE: begin
                    if (wr_ready && !last_idx) rd_idx_q <= rd_idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign rd_idx     = rd_idx_q;
    assign wr_en      = (state_q == S_WRITE);
    assign wr_addr    = {5'd0, rd_idx_q};
    assign wr_data    = wr_data_q;
    assign regs_clr_n = (state_q != S_CLEAR);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign empty_mask = empty_q;

endmodule
